aplic_irq_conditioner: RTL

APLIC_IRQ_CONDITIONER -- requirements
Module: aplic_irq_conditioner

---
 rtl/aplic_pkg.sv | 66 ++++++
 rtl/aplic_src_filter.sv | 77 +++++++
 rtl/aplic_irq_conditioner.sv | 117 +++++++++++
 3 files changed

// File: rtl/aplic_pkg.sv
// -----------------------------------------------------------------------------
// aplic_pkg
// Shared definitions for the APLIC interrupt-source conditioning path:
//   - sm_t        : 3-bit AIA sourcecfg SM field type
//   - SM_*        : raw SM encodings as carried in sourcecfg
//   - src_mode_e  : decoded source mode (reserved encodings fold to SRC_OFF)
//   - helpers     : SM decode and per-mode property queries
// -----------------------------------------------------------------------------
package aplic_pkg;

  typedef logic [2:0] sm_t;

  localparam sm_t SM_INACTIVE = 3'd0;
  localparam sm_t SM_DETACHED = 3'd1;
  localparam sm_t SM_RSVD2    = 3'd2;
  localparam sm_t SM_RSVD3    = 3'd3;
  localparam sm_t SM_EDGE1    = 3'd4;
  localparam sm_t SM_EDGE0    = 3'd5;
  localparam sm_t SM_LEVEL1   = 3'd6;
  localparam sm_t SM_LEVEL0   = 3'd7;

  localparam int NR_SRC_MAX = 1023;

  typedef enum logic [2:0] {
    SRC_OFF,
    SRC_DETACHED,
    SRC_EDGE1,
    SRC_EDGE0,
    SRC_LEVEL1,
    SRC_LEVEL0
  } src_mode_e;

  // Reserved encodings 2 and 3 behave exactly like inactive.
  function automatic src_mode_e decode_sm(input sm_t sm);
    src_mode_e mode;
    mode = SRC_OFF;
    case (sm)
      SM_DETACHED: mode = SRC_DETACHED;
      SM_EDGE1:    mode = SRC_EDGE1;
      SM_EDGE0:    mode = SRC_EDGE0;
      SM_LEVEL1:   mode = SRC_LEVEL1;
      SM_LEVEL0:   mode = SRC_LEVEL0;
      default:     mode = SRC_OFF;
    endcase
    return mode;
  endfunction

  // Active-low modes see the wire through an inverter.
  function automatic logic mode_inverts(input src_mode_e mode);
    return (mode == SRC_EDGE0) || (mode == SRC_LEVEL0);
  endfunction

  function automatic logic mode_is_edge(input src_mode_e mode);
    return (mode == SRC_EDGE1) || (mode == SRC_EDGE0);
  endfunction

  function automatic logic mode_is_level(input src_mode_e mode);
    return (mode == SRC_LEVEL1) || (mode == SRC_LEVEL0);
  endfunction

  // Modes in which the wire value is architecturally visible.
  function automatic logic mode_uses_wire(input src_mode_e mode);
    return mode_is_edge(mode) || mode_is_level(mode);
  endfunction

endpackage

// File: rtl/aplic_src_filter.sv
// -----------------------------------------------------------------------------
// aplic_src_filter
// Per-source synchronizer plus glitch filter. The raw wire is passed through a
// SYNC_STAGES-deep flop chain; the filtered bit only follows the synchronized
// value once it has disagreed for FILTER_CYCLES consecutive edges. With
// FILTER_CYCLES = 0 the synchronized value is forwarded unchanged.
//
// Ports
//   i_clk   : clock, all state on rising edge
//   ni_rst  : asynchronous active-low reset
//   i_src   : raw asynchronous source wire
//   o_filt  : synchronized, filtered level
// -----------------------------------------------------------------------------
module aplic_src_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic i_clk,
  input  logic ni_rst,
  input  logic i_src,
  output logic o_filt
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("aplic_src_filter: SYNC_STAGES must be at least 2");
    end
    if (FILTER_CYCLES < 0) begin : g_bad_filter
      $error("aplic_src_filter: FILTER_CYCLES must not be negative");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign o_filt = w_sync;
    end else begin : g_filter
      localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
      // The toggle happens on the edge that would have been the
      // FILTER_CYCLES-th mismatch, i.e. when the count already shows one less.
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

      logic [CNT_W-1:0] r_cnt;
      logic             r_filt;

      always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (w_sync == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_filt <= ~r_filt;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end

      assign o_filt = r_filt;
    end
  endgenerate

endmodule

// File: rtl/aplic_irq_conditioner.sv
// -----------------------------------------------------------------------------
// aplic_irq_conditioner
// Front end of the APLIC interrupt sources: synchronizes and de-glitches every
// raw source wire, then applies the per-source sourcecfg SM mode to produce
// the rectified input value, level-mode activity and edge-mode set-pending
// pulses.
//
// Ports
//   i_clk          : clock, all state on rising edge
//   ni_rst         : asynchronous active-low reset
//   i_irq_sources  : [NR_SRC]   raw asynchronous source wires
//   i_sm           : [NR_SRC]x3 per-source SM field, synchronous to i_clk
//   o_rect_in      : [NR_SRC]   rectified filtered value, SM 4..7 only
//   o_set_ip       : [NR_SRC]   one-cycle set-pending pulse, edge modes only
//   o_level_act    : [NR_SRC]   rectified level, level modes only
// -----------------------------------------------------------------------------
module aplic_irq_conditioner
  import aplic_pkg::*;
#(
  parameter int NR_SRC        = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                   i_clk,
  input  logic                   ni_rst,
  input  logic [NR_SRC-1:0]      i_irq_sources,
  input  logic [NR_SRC-1:0][2:0] i_sm,
  output logic [NR_SRC-1:0]      o_rect_in,
  output logic [NR_SRC-1:0]      o_set_ip,
  output logic [NR_SRC-1:0]      o_level_act
);

  generate
    if ((NR_SRC < 1) || (NR_SRC > NR_SRC_MAX)) begin : g_bad_nr_src
      $error("aplic_irq_conditioner: NR_SRC must be within 1..1023");
    end
  endgenerate

  logic [NR_SRC-1:0]      w_filt;
  logic [NR_SRC-1:0]      w_rect;
  logic [NR_SRC-1:0]      w_uses_wire;
  logic [NR_SRC-1:0]      w_is_edge;
  logic [NR_SRC-1:0]      w_is_level;
  logic [NR_SRC-1:0]      w_sm_stable;
  logic [NR_SRC-1:0]      r_rect_q;
  logic [NR_SRC-1:0][2:0] r_sm_q;
  logic                   r_out_en;

  // Sync chain and filter run in every mode so that enabling a source
  // immediately exposes its settled level.
  generate
    for (genvar g = 0; g < NR_SRC; g++) begin : g_src
      aplic_src_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
      ) u_filter (
        .i_clk  (i_clk),
        .ni_rst (ni_rst),
        .i_src  (i_irq_sources[g]),
        .o_filt (w_filt[g])
      );
    end
  endgenerate

  always_comb begin
    w_rect      = '0;
    w_uses_wire = '0;
    w_is_edge   = '0;
    w_is_level  = '0;
    w_sm_stable = '0;
    for (int i = 0; i < NR_SRC; i++) begin
      src_mode_e mode;
      mode           = decode_sm(i_sm[i]);
      w_rect[i]      = w_filt[i] ^ mode_inverts(mode);
      w_uses_wire[i] = mode_uses_wire(mode);
      w_is_edge[i]   = mode_is_edge(mode);
      w_is_level[i]  = mode_is_level(mode);
      // A mode change can flip the inversion and fake a rising rectified
      // value; edges are only trusted when the mode held across the edge.
      w_sm_stable[i] = (i_sm[i] == r_sm_q[i]);
    end
  end

  // rect_q and sm_q track the ungated values so the edge detector has a
  // correct history even while outputs are held off.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      r_rect_q <= '0;
      r_sm_q   <= '0;
    end else begin
      r_rect_q <= w_rect;
      r_sm_q   <= i_sm;
    end
  end

  // Outputs stay quiet during reset and the cycle following release; without
  // this an inverted mode would report active straight out of reset.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      r_out_en <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
    end
  end

  always_comb begin
    o_rect_in   = '0;
    o_level_act = '0;
    o_set_ip    = '0;
    if (r_out_en) begin
      o_rect_in   = w_rect & w_uses_wire;
      o_level_act = w_rect & w_is_level;
      o_set_ip    = w_rect & ~r_rect_q & w_is_edge & w_sm_stable;
    end
  end

endmodule
